// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response strobes and external asynchronous SRAM pins,
// bundled so the controller and its environment share one connection.
interface sram_mem_controller_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    // Pipeline + SRAM side: issues requests and returns SRAM read data
    modport master (
        output mem_r_en, mem_w_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    // Controller side
    modport slave (
        input  mem_r_en, mem_w_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit asynchronous SRAM
// accesses, holding ready low until both halves have completed.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_mem_controller_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 17;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic [WORD_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]   dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                we_n_q, we_n_d;

    logic                req;
    logic                in_phase_d;
    logic                half_d;
    logic                cap_lo;
    logic                cap_hi;
    logic [WORD_W-1:0]   offset;
    logic                unused_offset_bits;

    // Word index relative to BASE_ADDR with 32-bit wrap; byte lane bits dropped
    assign offset             = bus.address - WORD_W'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[WORD_W-1:IDX_W+2], offset[1:0]};

    assign req       = bus.mem_r_en | bus.mem_w_en;
    assign bus.ready = ((state_q == IDLE) && !req) || (state_q == DONE);

    assign bus.rdata       = rdata_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;

    // Read data is sampled on the last cycle of each halfword phase
    assign cap_lo = (state_q == LOW)  && (cnt_q == CNT_LAST) && !write_q;
    assign cap_hi = (state_q == HIGH) && (cnt_q == CNT_LAST) && !write_q;

    // Next-state logic and the SRAM pin values for the cycle being entered
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        in_phase_d  = 1'b0;
        half_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    write_d = bus.mem_w_en;
                    idx_d   = offset[IDX_W+1:2];
                    wdata_d = bus.wdata;
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        in_phase_d = (state_d == LOW) || (state_d == HIGH);
        half_d     = (state_d == HIGH);

        // we_n releases on the last phase cycle so its rising edge sees stable addr/data
        if (in_phase_d) begin
            sram_addr_d = {idx_d, half_d};
            dq_oe_d     = write_d;
            we_n_d      = !(write_d && (cnt_d != CNT_LAST));
            if (write_d) begin
                dq_out_d = half_d ? wdata_d[WORD_W-1:HALF_W] : wdata_d[HALF_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            if (cap_lo) begin
                rdata_q[HALF_W-1:0] <= bus.sram_dq_in;
            end
            if (cap_hi) begin
                rdata_q[WORD_W-1:HALF_W] <= bus.sram_dq_in;
            end
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized and directed bench for sram_mem_controller with a behavioural
// asynchronous SRAM and a word-level reference memory.
module tb_sram_mem_controller;
    localparam int unsigned BASE = 1024;
    localparam int unsigned WC   = 2;
    localparam int unsigned LAT  = 2 * WC + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_mem_controller_if bus ();

    sram_mem_controller #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Asynchronous SRAM: data latched on the rising edge of we_n
    logic [15:0] sram_mem [0:262143];
    assign bus.sram_dq_in = sram_mem[bus.sram_addr];
    always @(posedge bus.sram_we_n) begin
        if (bus.sram_dq_oe === 1'b1) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata;
    logic [31:0] ref_mem [int];
    logic [31:0] written_addrs [$];

    function automatic int unsigned word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'(BASE);
        return (off / 4) % 131072;
    endfunction

    // One full access; starts and ends just after a rising edge, leaves strobes as driven
    task automatic do_access(input logic r, input logic w, input logic [31:0] addr,
                             input logic [31:0] data, input string tag);
        int unsigned idx;
        int          c;
        bit          seen;
        int unsigned ph;
        bit          half;
        logic [17:0] e_addr;
        logic        e_we_n;
        idx = word_index(addr);
        if (!w) exp_rdata = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.address  = addr;
        bus.wdata    = data;
        c    = 0;
        seen = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                seen = 1;
            end else begin
                if (c >= 1 && c <= 2 * WC) begin
                    ph     = (c - 1) % WC;
                    half   = (c > WC);
                    e_addr = {17'(idx), half};
                    e_we_n = (w && ph < WC - 1) ? 1'b0 : 1'b1;
                    n_cmp++;
                    if (bus.sram_addr !== e_addr) begin
                        n_err++;
                        $display("FAIL %s addr cyc%0d: got %h expected %h", tag, c, bus.sram_addr, e_addr);
                    end
                    n_cmp++;
                    if (bus.sram_we_n !== e_we_n) begin
                        n_err++;
                        $display("FAIL %s we_n cyc%0d: got %b expected %b", tag, c, bus.sram_we_n, e_we_n);
                    end
                    n_cmp++;
                    if (bus.sram_dq_oe !== w) begin
                        n_err++;
                        $display("FAIL %s dq_oe cyc%0d: got %b expected %b", tag, c, bus.sram_dq_oe, w);
                    end
                    if (w) begin
                        n_cmp++;
                        if (bus.sram_dq_out !== (half ? data[31:16] : data[15:0])) begin
                            n_err++;
                            $display("FAIL %s dq_out cyc%0d: got %h expected %h", tag, c, bus.sram_dq_out,
                                     half ? data[31:16] : data[15:0]);
                        end
                    end
                end
                c++;
            end
        end
        n_cmp++;
        if (!seen || c != LAT) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d (ready seen=%0d)", tag, c, LAT, seen);
        end
        if (seen) begin
            n_cmp++;
            if (bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL %s rdata: got %h expected %h", tag, bus.rdata, exp_rdata);
            end
            n_cmp++;
            if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
                n_err++;
                $display("FAIL %s done pins: got we_n=%b oe=%b expected we_n=1 oe=0", tag, bus.sram_we_n, bus.sram_dq_oe);
            end
        end
        if (w) begin
            ref_mem[idx] = data;
            written_addrs.push_back(addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            n_cmp++;
            if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL idle: got ready=%b we_n=%b oe=%b rdata=%h expected 1 1 0 %h",
                         bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.rdata, exp_rdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_sram(input int unsigned a, input logic [15:0] e, input string tag);
        n_cmp++;
        if (sram_mem[a] !== e) begin
            n_err++;
            $display("FAIL %s sram[%0d]: got %h expected %h", tag, a, sram_mem[a], e);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.address  = 32'h0;
        bus.wdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_rdata = 32'h0;
        n_cmp++;
        if (bus.sram_addr !== 18'h0 || bus.sram_dq_out !== 16'h0 || bus.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset regs: got addr=%h dq=%h rdata=%h expected all zero",
                     bus.sram_addr, bus.sram_dq_out, bus.rdata);
        end
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
            n_err++;
            $display("FAIL reset pins: got ready=%b we_n=%b oe=%b expected 1 1 0",
                     bus.ready, bus.sram_we_n, bus.sram_dq_oe);
        end
        idle(4);
    endtask

    task automatic test_store_load();
        do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "store1024");
        check_sram(0, 16'hBEEF, "store1024");
        check_sram(1, 16'hDEAD, "store1024");
        idle(1);
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, "load1024");
        n_cmp++;
        if (exp_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL load1024 model: got %h expected %h", exp_rdata, 32'hDEADBEEF);
        end
        idle(3);
    endtask

    task automatic test_index3();
        do_access(1'b0, 1'b1, 32'd1036, 32'h12345678, "store1036");
        check_sram(6, 16'h5678, "store1036");
        check_sram(7, 16'h1234, "store1036");
        idle(1);
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, "load1036");
        idle(1);
    endtask

    task automatic test_reset_mid();
        bus.mem_r_en = 1'b1;
        bus.mem_w_en = 1'b0;
        bus.address  = 32'd1036;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.sram_addr !== 18'd7) begin
            n_err++;
            $display("FAIL rstmid high phase addr: got %h expected %h", bus.sram_addr, 18'd7);
        end
        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_rdata = 32'h0;
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.rdata !== 32'h0 || bus.sram_we_n !== 1'b1 || bus.sram_addr !== 18'h0) begin
            n_err++;
            $display("FAIL rstmid: got ready=%b rdata=%h we_n=%b addr=%h expected 1 0 1 0",
                     bus.ready, bus.rdata, bus.sram_we_n, bus.sram_addr);
        end
        idle(2);
    endtask

    task automatic test_both_strobes();
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, "preload");
        do_access(1'b1, 1'b1, 32'd1028, 32'h0000A5A5, "both");
        check_sram(2, 16'hA5A5, "both");
        check_sram(3, 16'h0000, "both");
        n_cmp++;
        if (bus.rdata !== 32'h12345678) begin
            n_err++;
            $display("FAIL both rdata kept: got %h expected %h", bus.rdata, 32'h12345678);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, "b2b_w0");
        do_access(1'b0, 1'b1, 32'd1044, 32'h0BADC0DE, "b2b_w1");
        do_access(1'b1, 1'b0, 32'd1040, 32'h0, "b2b_r0");
        do_access(1'b1, 1'b0, 32'd1044, 32'h0, "b2b_r1");
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] data;
        int          woff;
        logic        r;
        logic        w;
        for (int i = 0; i < 40; i++) begin
            if (i < 8 || ($urandom % 2) == 0) begin
                woff = int'($urandom_range(0, 31)) - 16;
                addr = 32'(BASE) + 32'(woff * 4) + 32'($urandom_range(0, 3));
                data = $urandom;
                w    = 1'b1;
                r    = (($urandom % 4) == 0);
            end else begin
                addr = written_addrs[$urandom_range(0, written_addrs.size() - 1)];
                addr = {addr[31:2], 2'($urandom_range(0, 3))};
                data = $urandom;
                w    = 1'b0;
                r    = 1'b1;
            end
            do_access(r, w, addr, data, w ? "rand_wr" : "rand_rd");
            if (($urandom % 3) != 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_index3();
        test_reset_mid();
        test_both_strobes();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Responder for the MEM-stage read/write strobes produced by instruction decode.
- Converts one 32-bit load or store into two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low until the access completes; the pipeline freeze logic uses `ready` to stall all stages.
- Sits between the MEM stage and the board SRAM pins, in place of the on-chip data memory.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles per halfword phase. Legal range is 2..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request from MEM stage; held stable while ready=0.
- mem_w_en  in  1  store request from MEM stage; held stable while ready=0.
- address  in  32  byte address from ALU result.
- wdata  in  32  store data (Rm value).
- rdata  out  32  load data; registered.
- ready  out  1  1 = MEM stage may advance; 0 = freeze pipeline.
- sram_addr  out  18  SRAM halfword address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned by SRAM.
- sram_dq_oe  out  1  1 = FPGA drives the DQ bus.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state IDLE, phase counter 0
  - rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1
  - Reset mid-access abandons the access. A partially written word may remain in SRAM; this is accepted.
- Address mapping:
  - word index = (address - BASE_ADDR) >> 2, using 32-bit wrap-around subtraction; bits [1:0] of the address are ignored.
  - sram_addr = {index[16:0], half}, where half=0 selects bits [15:0] and half=1 selects bits [31:16].
  - Addresses below BASE_ADDR wrap. No error flag is raised.
- Request and priority:
  - req = mem_r_en | mem_w_en.
  - If both are high, the access is a write; rdata is left unchanged.
- States:
  - IDLE: if req, latch op, index and wdata, then go to LOW with counter 0. Otherwise stay.
  - LOW: counter runs 0..WAIT_CYCLES-1; at WAIT_CYCLES-1 go to HIGH with counter 0.
  - HIGH: same counting; at WAIT_CYCLES-1 go to DONE.
  - DONE: go to IDLE after one cycle.
- ready is combinational:
  - ready = (state==IDLE & ~req) | (state==DONE).
  - It drops in the same cycle a request first appears.
  - The pipeline advances on the edge that leaves DONE.
- Latency: ready is first high 2*WAIT_CYCLES+1 cycles after the request appears. With WAIT_CYCLES=2 that is 5 cycles.
- Write phases:
  - sram_dq_oe=1, with sram_dq_out set to the phase's half of the latched wdata.
  - sram_we_n=0 for counter < WAIT_CYCLES-1 and 1 on the last cycle of the phase, so the rising edge falls inside a stable address/data window.
- Read phases:
  - sram_dq_oe=0, sram_we_n=1.
  - On the last cycle of LOW, sram_dq_in is captured into rdata[15:0]; on the last cycle of HIGH, into rdata[31:16].
  - rdata holds its value until the next read overwrites it.
- Inputs are ignored outside IDLE; the latched op, index and wdata govern the whole access.
- A request still high in the IDLE cycle after DONE starts a new access. The pipeline guarantees the strobes belong to the next instruction by then.
- In IDLE and DONE, sram_we_n=1 and sram_dq_oe=0.

Test Plan:
- Reset, then idle with no requests -> ready=1 every cycle; sram_we_n=1, sram_dq_oe=0, rdata=0.
- Store address=1024, wdata=0xDEADBEEF, WAIT_CYCLES=2:
  - ready=0 for 5 cycles, then high for 1 cycle.
  - sram_addr=0 with dq_out=0xBEEF, then sram_addr=1 with dq_out=0xDEAD.
  - sram_we_n pulses low for one cycle in each phase.
- Load address=1024 with an SRAM model preloaded by the previous store -> rdata=0xDEADBEEF when ready rises; rdata still holds the value 3 cycles later.
- Store address=1036, wdata=0x12345678, then load address=1036 -> sram_addr uses index 3 (6 and 7); rdata=0x12345678.
- Assert rst during the HIGH phase of a load -> next cycle state IDLE, rdata=0, ready=1 with no request.
- mem_r_en=mem_w_en=1 at address=1028 with wdata=0xA5A5 -> write performed at sram_addr 2 and 3; rdata unchanged.
